// File: rtl/md_unit_if.sv
// Handshake and result bus between the EX-stage control and the multiply/divide unit.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  modport master (
    output start, md_op, A, B, rd_sel,
    input  busy, hi, lo, md_rdata
  );

  modport slave (
    input  start, md_op, A, B, rd_sel,
    output busy, hi, lo, md_rdata
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit: result is computed at acceptance, held
// in pending registers and committed to HI/LO when the busy countdown expires.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned W2 = 64;
  localparam int unsigned CW = 4;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [W-1:0]   hi_q, hi_n, lo_q, lo_n;
  logic [W-1:0]   pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic           pend_wr, pend_wr_n;

  logic [W2-1:0]  prod_s, prod_u;
  logic [W-1:0]   a_mag, b_mag, b_safe, quo, rem, quo_out, rem_out;
  logic           div_signed;

  // Products; signed operands are sign-extended before multiplying.
  assign prod_s = W2'($signed(bus.A)) * W2'($signed(bus.B));
  assign prod_u = W2'(bus.A) * W2'(bus.B);

  // Signed divide done on magnitudes, then signs restored (truncation toward zero).
  always_comb begin
    div_signed = (bus.md_op == OP_DIV);
    a_mag      = (div_signed && bus.A[W-1]) ? W'(-bus.A) : bus.A;
    b_mag      = (div_signed && bus.B[W-1]) ? W'(-bus.B) : bus.B;
    b_safe     = (b_mag == '0) ? W'(1) : b_mag;
    quo        = a_mag / b_safe;
    rem        = a_mag % b_safe;
    quo_out    = (div_signed && (bus.A[W-1] ^ bus.B[W-1])) ? W'(-quo) : quo;
    rem_out    = (div_signed && bus.A[W-1]) ? W'(-rem) : rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          unique case (bus.md_op)
            OP_MULT: begin
              {pend_hi_n, pend_lo_n} = prod_s;
              pend_wr_n = 1'b1;
              cnt_n     = CW'(MULT_CYCLES);
              state_n   = S_RUN;
            end
            OP_MULTU: begin
              {pend_hi_n, pend_lo_n} = prod_u;
              pend_wr_n = 1'b1;
              cnt_n     = CW'(MULT_CYCLES);
              state_n   = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_n = rem_out;
              pend_lo_n = quo_out;
              // Divide by zero still runs the busy sequence but never commits.
              pend_wr_n = (bus.B != '0);
              cnt_n     = CW'(DIV_CYCLES);
              state_n   = S_RUN;
            end
            OP_MTHI: hi_n = bus.A;
            OP_MTLO: lo_n = bus.A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = S_IDLE;
          if (pend_wr) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.busy     = (state == S_RUN);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_rdata = bus.rd_sel ? hi_q : lo_q;
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu over multiple cycles into the HI/LO registers, and handles mthi/mtlo writes and mfhi/mflo reads.
- Drives `busy` into the stall unit, which holds any MD-class instruction in D while `busy` is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (1..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  an MD instruction is in E this cycle; op on md_op.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved.
- A  input  32  rs operand (forwarded value from E).
- B  input  32  rt operand (forwarded value from E).
- rd_sel  input  1  mf read select: 0 LO, 1 HI.
- busy  output  1  multi-cycle operation in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.
- md_rdata  output  32  combinational: rd_sel ? hi : lo, used for mfhi/mflo.

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, pending result=0. Reset has priority over every other event, including mid-operation; an in-flight result is discarded.
- Acceptance:
  - An op is accepted on an edge where start=1, busy=0 and md_op is in 1..6.
  - start with busy=1 is ignored entirely; the stall unit guarantees this case does not occur.
  - md_op 0 or 7 with start=1 is a no-op.
- mthi/mtlo (op 5/6): hi (or lo) <= A on the accepting edge. Visible the next cycle; busy stays 0.
- mult/multu/div/divu, at the accepting edge:
  - Compute the result from A and B and store it in pending HI/LO registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES, and set busy=1.
- Countdown:
  - While busy, the counter decrements each edge.
  - On the edge where the counter goes 1->0, pending is written to hi/lo and busy goes to 0 on that same edge.
  - Net effect: busy is high for exactly N cycles, starting the cycle after start. hi/lo show the new values in the first cycle with busy=0.
  - hi/lo hold their old values throughout busy, so mf reads during busy would return old values; the stall unit prevents such reads.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product, hi = [63:32], lo = [31:0].
  - multu: the same, unsigned.
  - div: signed. lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend A.
  - divu: unsigned quotient and remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (B=0, div or divu): the busy sequence runs normally, but hi/lo are left unchanged at commit.
- md_rdata is purely combinational from rd_sel, hi and lo. There is no bypass of a pending result.
- No exception or interrupt cancellation in this revision.

Test Plan:
- Signed multiply: reset, then start mult with A=0xFFFFFFFD (-3), B=7.
  - busy=1 for exactly 5 cycles.
  - Next cycle: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned multiply and read select: multu with A=0xFFFFFFFF, B=2.
  - After 5 busy cycles: hi=0x00000001, lo=0xFFFFFFFE.
  - md_rdata follows rd_sel (1 -> 0x00000001, 0 -> 0xFFFFFFFE).
- Signed divide and overflow: div with A=0xFFFFFFF9 (-7), B=2.
  - busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div with A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0.
- Unsigned divide and divide by zero:
  - divu with A=7, B=2: lo=3, hi=1.
  - Then div with A=5, B=0: busy for 10 cycles, hi/lo remain 1/3.
- Move ops and ignored start:
  - mthi with A=0x12345678: hi updated next cycle, busy never asserts.
  - Start mult, and during its busy cycles pulse start with mtlo and with div: both ignored, lo/hi reflect only the mult result.
- Reset mid-operation: start div, assert reset at busy cycle 4.
  - Next cycle: busy=0, hi=lo=0.
  - No later commit occurs.
  - A fresh mult completes normally afterwards.
